// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a synchronous fifo and sends them as
// start bit, DATA_WIDTH data bits LSB first, then STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CLOCKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  read_enable_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    input  logic                  read_valid_i,
    input  logic                  fifo_empty_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]            r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;

    logic                  w_baud_last;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_baud_last  = (r_baud == BAUD_LAST);
    assign w_shift_next = r_shift >> 1;

    assign read_enable_o = (r_state == S_IDLE) && !fifo_empty_i && !reset_i;
    assign busy_o        = (r_state != S_IDLE);
    assign frame_done_o  = (r_state == S_STOP) && w_baud_last && (r_bit == STOP_LAST);
    assign tx_o          = r_tx;

    // r_tx is loaded with the level of the state being entered, so the line
    // changes in the same cycle the new state becomes current.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!fifo_empty_i) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (read_valid_i) begin
                        r_shift <= read_data_i;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == DATA_LAST) begin
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_shift <= w_shift_next;
                            r_tx    <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == STOP_LAST) begin
                            r_bit   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: lane 0 runs STOP_BITS=1, lane 1 runs STOP_BITS=2; a fifo
// model queues expected frames on each pop and a line monitor decodes tx.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;

    typedef struct packed {
        logic [7:0]  d;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst   = 2'b11;
    logic [1:0]      rs    = 2'b11;
    logic [1:0]      rv    = 2'b00;
    logic [1:0]      empty = 2'b11;
    logic [1:0]      ghost = 2'b00;
    logic [1:0][7:0] rd    = '0;

    logic tx0, tx1, busy0, busy1, fd0, fd1, re0, re1;
    logic [1:0] tx, busy, fd, re;
    assign tx   = {tx1, tx0};
    assign busy = {busy1, busy0};
    assign fd   = {fd1, fd0};
    assign re   = {re1, re0};

    logic [7:0]  fq [2][$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cyc = '0;
    int          pops   [2] = '{0, 0};
    int          frames [2] = '{0, 0};
    int          gaps   [2] = '{0, 0};
    logic [31:0] last_done [2] = '{32'hFFFF_0000, 32'hFFFF_0000};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rs  <= rst;
    end

    fifo_uart_tx #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut0 (
        .clk_i(clk), .reset_i(rst[0]), .read_enable_o(re0), .read_data_i(rd[0]),
        .read_valid_i(rv[0]), .fifo_empty_i(empty[0]), .tx_o(tx0),
        .busy_o(busy0), .frame_done_o(fd0)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut1 (
        .clk_i(clk), .reset_i(rst[1]), .read_enable_o(re1), .read_data_i(rd[1]),
        .read_valid_i(rv[1]), .fifo_empty_i(empty[1]), .tx_o(tx1),
        .busy_o(busy1), .frame_done_o(fd1)
    );

    task automatic chk(input string name, input int got, input int expv);
        n_vec++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic string ln(input int lane, input string s);
        return $sformatf("L%0d_%s", lane, s);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned SB  = (g == 0) ? 1 : 2;
        localparam int unsigned LEN = CPB * (1 + 8 + SB);

        ent_t        exq [$];
        ent_t        e_pop;
        ent_t        e_cur;
        logic        pend;
        logic [31:0] pcyc;
        int unsigned pos;
        int unsigned bitn;
        logic        exp_tx;
        logic        in_frame = 1'b0;
        int          wave_bad, fd_bad, busy_bad;
        logic [7:0]  got;

        // Fifo with one-cycle read latency; the popped word becomes an expected frame.
        always begin : fifo_model
            @(negedge clk);
            pend = re[g];
            pcyc = cyc;
            @(posedge clk);
            #1;
            if (pend && !ghost[g] && fq[g].size() > 0) begin
                e_pop.d  = fq[g].pop_front();
                e_pop.pc = pcyc;
                rd[g]    = e_pop.d;
                rv[g]    = 1'b1;
                exq.push_back(e_pop);
                pops[g]++;
            end else begin
                rv[g] = 1'b0;
                rd[g] = 8'($urandom);
            end
            #1;
            empty[g] = ghost[g] ? 1'b0 : (fq[g].size() == 0);
        end

        always @(negedge clk) begin : line_monitor
            chk(ln(g, "pop_in_reset"), int'(re[g] & rst[g]), 0);
            chk(ln(g, "pop_while_busy"), int'(re[g] & busy[g]), 0);
            if (rs[g]) begin
                chk(ln(g, "rst_tx"), int'(tx[g]), 1);
                chk(ln(g, "rst_busy"), int'(busy[g]), 0);
                chk(ln(g, "rst_done"), int'(fd[g]), 0);
                in_frame = 1'b0;
                exq.delete();
            end else begin
                if (!in_frame) begin
                    chk(ln(g, "idle_done"), int'(fd[g]), 0);
                    if (!tx[g]) begin
                        chk(ln(g, "start_expected"), int'(exq.size() > 0), 1);
                        if (exq.size() > 0) begin
                            e_cur = exq.pop_front();
                            chk(ln(g, "start_latency"), int'(cyc - e_cur.pc), 2);
                            if (e_cur.pc == last_done[g] + 1) begin
                                chk(ln(g, "b2b_gap"), int'(cyc - last_done[g]), 3);
                                gaps[g]++;
                            end
                            in_frame = 1'b1;
                            pos      = 0;
                            wave_bad = 0;
                            fd_bad   = 0;
                            busy_bad = 0;
                            got      = '0;
                        end
                    end
                end
                if (in_frame) begin
                    bitn   = pos / CPB;
                    exp_tx = (bitn == 0) ? 1'b0 : (bitn <= 8) ? e_cur.d[bitn-1] : 1'b1;
                    if (tx[g] !== exp_tx) wave_bad++;
                    if (fd[g] !== (pos == LEN - 1)) fd_bad++;
                    if (busy[g] !== 1'b1) busy_bad++;
                    if (bitn >= 1 && bitn <= 8 && (pos % CPB) == CPB / 2) got[bitn-1] = tx[g];
                    if (pos == LEN - 1) begin
                        chk(ln(g, "wave_cycles_wrong"), wave_bad, 0);
                        chk(ln(g, "done_cycles_wrong"), fd_bad, 0);
                        chk(ln(g, "busy_cycles_low"), busy_bad, 0);
                        chk(ln(g, "data_byte"), int'(got), int'(e_cur.d));
                        frames[g]++;
                        last_done[g] = cyc;
                        in_frame = 1'b0;
                    end else begin
                        pos++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_frames(input int lane, input int target, input int budget);
        int n = 0;
        while (frames[lane] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(ln(lane, "frames_by_deadline"), frames[lane], target);
    endtask

    initial begin : stimulus
        int f0, p0, g0, cnt, total, burst;
        logic [7:0] v;

        repeat (5) step();
        @(negedge clk);
        chk("reset_tx", int'(tx0), 1);
        chk("reset_pop", int'(re0), 0);
        chk("reset_done", int'(fd0), 0);
        step();
        rst = 2'b00;

        // Idle line with an empty fifo
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_tx", int'(tx[0] & tx[1]), 1);
            chk("idle_pop", int'(re[0] | re[1]), 0);
            chk("idle_busy", int'(busy[0] | busy[1]), 0);
        end

        // Single 0xA5 frame
        f0 = frames[0]; p0 = pops[0];
        step();
        fq[0].push_back(8'hA5);
        wait_frames(0, f0 + 1, 200);
        chk("a5_pops", pops[0] - p0, 1);

        // Back-to-back 0x00, 0xFF
        f0 = frames[0]; p0 = pops[0]; g0 = gaps[0];
        step();
        fq[0].push_back(8'h00);
        fq[0].push_back(8'hFF);
        wait_frames(0, f0 + 2, 300);
        chk("b2b_pops", pops[0] - p0, 2);
        chk("b2b_gap_checked", gaps[0] - g0, 1);

        // Fifo claims data but never delivers it
        f0 = frames[0];
        step();
        ghost[0] = 1'b1;
        repeat (4) step();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt += int'(re[0]);
            chk("ghost_tx", int'(tx[0]), 1);
        end
        chk("ghost_retries", cnt, 10);
        chk("ghost_frames", frames[0] - f0, 0);
        step();
        ghost[0] = 1'b0;
        fq[0].push_back(8'h33);
        wait_frames(0, f0 + 1, 200);

        // Reset during data bit 3 of 0x3C, with another word waiting
        f0 = frames[0];
        step();
        fq[0].push_back(8'h3C);
        cnt = 0;
        while (tx[0] !== 1'b0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_start_seen", int'(tx[0]), 0);
        repeat (17) step();
        rst[0] = 1'b1;
        fq[0].push_back(8'h5A);
        @(negedge clk);
        @(negedge clk);
        chk("abort_tx", int'(tx[0]), 1);
        chk("abort_busy", int'(busy[0]), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_pop", int'(re[0]), 0);
        end
        step();
        rst[0] = 1'b0;
        wait_frames(0, f0 + 1, 200);
        chk("abort_queue_drained", fq[0].size(), 0);

        // Two stop bits: 0x80
        f0 = frames[1];
        step();
        fq[1].push_back(8'h80);
        wait_frames(1, f0 + 1, 200);

        // Random bursts on both lanes
        for (int lane = 0; lane < 2; lane++) begin
            f0 = frames[lane]; p0 = pops[lane];
            total = 0;
            for (int i = 0; i < ((lane == 0) ? 12 : 5); i++) begin
                burst = $urandom_range(1, 3);
                for (int b = 0; b < burst; b++) begin
                    v = 8'($urandom);
                    fq[lane].push_back(v);
                    total++;
                end
                repeat ($urandom_range(0, 120)) step();
            end
            wait_frames(lane, f0 + total, total * 60 + 200);
            chk(ln(lane, "rand_pops"), pops[lane] - p0, total);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run exceeded time limit, vectors %0d", n_vec);
        $fatal(1);
    end

endmodule
